dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 tb/tb_dmem_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-outstanding data-memory responder with a valid/ready
//               request and response handshake. It supports byte, halfword
//               and word loads and stores. Loads are sign- or zero-extended.
//               Misaligned or illegal requests receive an error response.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_read_en,
    input  logic        i_write_en,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    localparam int ADDR_BITS = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [31:0]            r_mem [DEPTH_WORDS];
    logic [31:0]            r_word;
    logic [1:0]             r_offset;
    logic [2:0]             r_load_f3;
    logic [31:0]            r_rdata;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_size_err;
    logic                   w_err;
    logic                   w_store_commit;
    logic                   w_load_start;
    logic [ADDR_BITS-1:0]   w_index;
    logic [3:0]             w_be;
    logic [31:0]            w_lanes;
    logic [31:0]            w_load_data;

    // Address bits above the storage range are intentionally ignored (wrap).
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, i_addr[31:ADDR_BITS+2]};

    // Requests are taken only in IDLE, and never while reset is held.
    assign o_req_ready = (r_state == IDLE) & ~i_rst;
    assign w_accept    = i_req_valid & o_req_ready;
    assign w_index     = i_addr[ADDR_BITS+1:2];

    assign o_rsp_valid = (r_state == RSP);
    assign o_rdata     = r_rdata;
    assign o_err       = r_err;

    // Decode the size/alignment legality of the incoming request.
    always_comb begin
        w_size_err = 1'b1;
        case (i_funct3)
            3'b000, 3'b100: w_size_err = 1'b0;
            3'b001, 3'b101: w_size_err = i_addr[0];
            3'b010:         w_size_err = |i_addr[1:0];
            default:        w_size_err = 1'b1;
        endcase
    end

    // An error covers bad size/alignment, unsigned stores and ambiguous commands.
    assign w_err          = w_size_err
                          | ~(i_read_en ^ i_write_en)
                          | (i_write_en & i_funct3[2]);
    assign w_store_commit = w_accept & ~w_err & i_write_en;
    assign w_load_start   = w_accept & ~w_err & i_read_en;

    // Select the byte lanes and replicate the right-aligned store data onto them.
    always_comb begin
        w_be    = 4'b0000;
        w_lanes = 32'd0;
        case (i_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_lanes = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{i_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_lanes = i_wdata;
            end
        endcase
    end

    // Storage array and load capture; neither is reset, so contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_store_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_index][8*b +: 8] <= w_lanes[8*b +: 8];
                end
            end
        end
        if (w_load_start) begin
            r_word    <= r_mem[w_index];
            r_offset  <= i_addr[1:0];
            r_load_f3 <= i_funct3;
        end
    end

    // Extract and extend the addressed byte/halfword from the captured word.
    always_comb begin
        w_load_data = r_word;
        case (r_load_f3)
            3'b000:  w_load_data = {{24{r_word[{r_offset, 3'b000} + 7]}}, r_word[{r_offset, 3'b000} +: 8]};
            3'b100:  w_load_data = {24'd0, r_word[{r_offset, 3'b000} +: 8]};
            3'b001:  w_load_data = {{16{r_word[{r_offset[1], 4'b0000} + 15]}}, r_word[{r_offset[1], 4'b0000} +: 16]};
            3'b101:  w_load_data = {16'd0, r_word[{r_offset[1], 4'b0000} +: 16]};
            default: w_load_data = r_word;
        endcase
    end

    // Response payload: cleared at accept, filled with load data on RD->RSP.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= 32'd0;
            r_err   <= w_err;
        end else if (r_state == RD) begin
            r_rdata <= w_load_data;
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: loads take the extra RD cycle, everything else goes to RSP.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_load_start ? RD : RSP;
                end
            end
            RD:      w_next_state = RSP;
            RSP: begin
                if (i_rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. It runs directed
//               scenarios, then randomized traffic that is compared against a
//               byte-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        read_en = 1'b0;
    logic        write_en = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rdata;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mbytes [1024];

    dmem_responder #(.DEPTH_WORDS(256)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_read_en   (read_en),
        .i_write_en  (write_en),
        .i_funct3    (funct3),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rdata     (rdata),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference model: byte-addressed memory of 1024 bytes, rules applied directly.
    function automatic void model_ref(input logic re, input logic we, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] wd,
                                      output logic [31:0] rd, output logic er, output int lat);
        int ba;
        int base;
        bit bad;
        logic [7:0]  b;
        logic [15:0] h;
        ba  = int'(a[9:0]);
        bad = (re == we);
        case (f3)
            3'd0, 3'd4: ;
            3'd1, 3'd5: if (ba % 2 != 0) bad = 1;
            3'd2:       if (ba % 4 != 0) bad = 1;
            default:    bad = 1;
        endcase
        if (we && f3 >= 3'd4) bad = 1;
        rd = 32'd0; er = 1'b0; lat = 1;
        if (bad) begin
            er = 1'b1;
            return;
        end
        if (we) begin
            case (f3)
                3'd0: mbytes[ba] = wd[7:0];
                3'd1: begin
                    base = ba - ba % 2;
                    mbytes[base] = wd[7:0]; mbytes[base+1] = wd[15:8];
                end
                default: begin
                    for (int k = 0; k < 4; k++) mbytes[ba+k] = wd[8*k +: 8];
                end
            endcase
            return;
        end
        lat = 2;
        b = mbytes[ba];
        h = {mbytes[ba - ba % 2 + 1], mbytes[ba - ba % 2]};
        case (f3)
            3'd0:    rd = {{24{b[7]}}, b};
            3'd4:    rd = {24'd0, b};
            3'd1:    rd = {{16{h[15]}}, h};
            3'd5:    rd = {16'd0, h};
            default: rd = {mbytes[ba+3], mbytes[ba+2], mbytes[ba+1], mbytes[ba]};
        endcase
    endfunction

    // Drive one request and collect its response; latency counts edges from accept.
    task automatic do_req(input logic re, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int stall,
                          output logic [31:0] rd, output logic er, output int lat, output bit to);
        int w;
        to = 0; lat = 0; rd = 'x; er = 'x;
        @(negedge clk);
        req_valid = 1'b1; read_en = re; write_en = we; funct3 = f3; addr = a; wdata = wd;
        w = 0;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        if (!req_ready) begin to = 1; req_valid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        read_en = 1'($urandom); write_en = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        if (!rsp_valid) begin to = 1; return; end
        rd = rdata; er = err;
        repeat (stall) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rdata !== 32'd0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_held: valid=%b ready=%b rdata=%h err=%b, want 0 0 00000000 0", rsp_valid, req_ready, rdata, err);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] rd; logic er; int lat; bit to;
        do_req(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, to);
        n_cmp++;
        if (to || er !== 1'b0 || rd !== 32'd0 || lat != 1) begin n_bad++;
            $display("FAIL sw_10: rdata=%h err=%b lat=%0d to=%b, want 00000000 0 1 0", rd, er, lat, to); end
        do_req(1, 0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat, to);
        n_cmp++;
        if (to || er !== 1'b0 || rd !== 32'hDEADBEEF || lat != 2) begin n_bad++;
            $display("FAIL lw_10: rdata=%h err=%b lat=%0d to=%b, want deadbeef 0 2 0", rd, er, lat, to); end
        do_req(0, 1, 3'b000, 32'h11, 32'h80, 1, rd, er, lat, to);
        do_req(1, 0, 3'b000, 32'h11, 32'h0, 0, rd, er, lat, to);
        n_cmp++;
        if (to || er !== 1'b0 || rd !== 32'hFFFFFF80) begin n_bad++;
            $display("FAIL lb_11: rdata=%h err=%b to=%b, want ffffff80 0 0", rd, er, to); end
        do_req(1, 0, 3'b100, 32'h11, 32'h0, 0, rd, er, lat, to);
        n_cmp++;
        if (to || er !== 1'b0 || rd !== 32'h00000080) begin n_bad++;
            $display("FAIL lbu_11: rdata=%h err=%b to=%b, want 00000080 0 0", rd, er, to); end
        do_req(1, 0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat, to);
        n_cmp++;
        if (to || er !== 1'b0 || rd !== 32'hDEAD80EF) begin n_bad++;
            $display("FAIL lw_10_after_sb: rdata=%h err=%b to=%b, want dead80ef 0 0", rd, er, to); end
        do_req(1, 0, 3'b010, 32'h12, 32'h0, 0, rd, er, lat, to);
        n_cmp++;
        if (to || er !== 1'b1 || rd !== 32'd0 || lat != 1) begin n_bad++;
            $display("FAIL lw_misaligned: rdata=%h err=%b lat=%0d to=%b, want 00000000 1 1 0", rd, er, lat, to); end
        do_req(0, 1, 3'b001, 32'h13, 32'h5555, 0, rd, er, lat, to);
        n_cmp++;
        if (to || er !== 1'b1 || rd !== 32'd0) begin n_bad++;
            $display("FAIL sh_misaligned: rdata=%h err=%b to=%b, want 00000000 1 0", rd, er, to); end
        do_req(1, 1, 3'b010, 32'h10, 32'h11111111, 0, rd, er, lat, to);
        n_cmp++;
        if (to || er !== 1'b1 || rd !== 32'd0) begin n_bad++;
            $display("FAIL both_enables: rdata=%h err=%b to=%b, want 00000000 1 0", rd, er, to); end
        do_req(0, 1, 3'b011, 32'h10, 32'h22222222, 0, rd, er, lat, to);
        n_cmp++;
        if (to || er !== 1'b1) begin n_bad++;
            $display("FAIL funct3_011: err=%b to=%b, want 1 0", er, to); end
        do_req(0, 1, 3'b100, 32'h10, 32'h33, 0, rd, er, lat, to);
        n_cmp++;
        if (to || er !== 1'b1) begin n_bad++;
            $display("FAIL store_unsigned: err=%b to=%b, want 1 0", er, to); end
        do_req(1, 0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat, to);
        n_cmp++;
        if (to || er !== 1'b0 || rd !== 32'hDEAD80EF) begin n_bad++;
            $display("FAIL lw_10_unchanged: rdata=%h err=%b to=%b, want dead80ef 0 0", rd, er, to); end
        do_req(0, 1, 3'b010, 32'h400, 32'h12345678, 0, rd, er, lat, to);
        do_req(1, 0, 3'b010, 32'h0, 32'h0, 0, rd, er, lat, to);
        n_cmp++;
        if (to || er !== 1'b0 || rd !== 32'h12345678) begin n_bad++;
            $display("FAIL addr_wrap: rdata=%h err=%b to=%b, want 12345678 0 0", rd, er, to); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; bit to; int n;
        @(negedge clk);
        req_valid = 1'b1; read_en = 1'b1; write_en = 1'b0; funct3 = 3'b010; addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        // Keep a competing store on the inputs while busy; it must be ignored.
        read_en = 1'b0; write_en = 1'b1; addr = 32'h10; wdata = 32'h0BADF00D;
        n = 0;
        while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (rsp_valid !== 1'b1 || rdata !== 32'hDEAD80EF || err !== 1'b0 || req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL backpressure_hold cyc%0d: valid=%b rdata=%h err=%b ready=%b, want 1 dead80ef 0 0",
                         i, rsp_valid, rdata, err, req_ready);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL backpressure_release: valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
        end
        do_req(1, 0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat, to);
        n_cmp++;
        if (to || er !== 1'b0 || rd !== 32'hDEAD80EF) begin n_bad++;
            $display("FAIL busy_inputs_ignored: rdata=%h err=%b to=%b, want dead80ef 0 0", rd, er, to); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; bit to;
        // Reset while in RD.
        @(negedge clk);
        req_valid = 1'b1; read_en = 1'b1; write_en = 1'b0; funct3 = 3'b010; addr = 32'h0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rdata !== 32'd0 || err !== 1'b0) begin n_bad++;
            $display("FAIL reset_in_rd: valid=%b ready=%b rdata=%h err=%b, want 0 0 00000000 0", rsp_valid, req_ready, rdata, err); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++;
            $display("FAIL reset_in_rd_release: valid=%b ready=%b, want 0 1", rsp_valid, req_ready); end
        // Reset while a committed store is in RSP.
        @(negedge clk);
        req_valid = 1'b1; read_en = 1'b0; write_en = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'hA5A50F0F;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin n_bad++;
            $display("FAIL reset_in_rsp: valid=%b, want 0", rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        do_req(1, 0, 3'b010, 32'h20, 32'h0, 0, rd, er, lat, to);
        n_cmp++;
        if (to || er !== 1'b0 || rd !== 32'hA5A50F0F || lat != 2) begin n_bad++;
            $display("FAIL store_survives_reset: rdata=%h err=%b lat=%0d to=%b, want a5a50f0f 0 2 0", rd, er, lat, to); end
        do_req(1, 0, 3'b010, 32'h0, 32'h0, 0, rd, er, lat, to);
        n_cmp++;
        if (to || er !== 1'b0 || rd !== 32'h12345678) begin n_bad++;
            $display("FAIL resume_after_reset: rdata=%h err=%b to=%b, want 12345678 0 0", rd, er, to); end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp_rd, a, wd; logic er, exp_er, re, we; logic [2:0] f3;
        int lat, exp_lat, r; bit to;
        // Give every word a known value so all later loads are defined.
        for (int w = 0; w < 256; w++) begin
            wd = $urandom;
            model_ref(1'b0, 1'b1, 3'b010, w * 4, wd, exp_rd, exp_er, exp_lat);
            do_req(1'b0, 1'b1, 3'b010, w * 4, wd, 0, rd, er, lat, to);
        end
        for (int i = 0; i < 200; i++) begin
            r  = $urandom_range(0, 9);
            re = (r == 0) || (r >= 2 && r <= 5);
            we = (r == 0) || (r >= 6);
            f3 = 3'($urandom_range(0, 2));
            if (re && f3 != 3'd2 && $urandom_range(0, 1) == 1) f3 = f3 | 3'b100;
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
            end
            wd = $urandom;
            model_ref(re, we, f3, a, wd, exp_rd, exp_er, exp_lat);
            do_req(re, we, f3, a, wd, $urandom_range(0, 3), rd, er, lat, to);
            n_cmp++;
            if (to || er !== exp_er || rd !== exp_rd || lat != exp_lat) begin
                n_bad++;
                $display("FAIL random#%0d re=%b we=%b f3=%b addr=%h wd=%h: rdata=%h err=%b lat=%0d to=%b, want %h %b %0d 0",
                         i, re, we, f3, a, wd, rd, er, lat, to, exp_rd, exp_er, exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
